// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the
// parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    NON_OVL = 1'b0,
    OVL     = 1'b1
  } ovl_mode_t;

  localparam logic [3:0] PAT_RST_DEF = 4'b1010;
  localparam int         CNT_W_DEF   = 8;

endpackage

// File: rtl/seq_det_hist.sv
// History shift register and fill counter for
// the serial pattern detector.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic               flush,
  input  logic               x,
  output logic [PAT_LEN-2:0] hist,
  output logic               full
);

  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

  logic [FW-1:0]      fill;
  logic [PAT_LEN-2:0] nxt;

  if (PAT_LEN > 2) begin : g_wide
    assign nxt = {hist[PAT_LEN-3:0], x};
  end else begin : g_one
    assign nxt = x;
  end

  assign full = (fill == FILL_MAX);

  // Flush clears everything; a flushed history is
  // fully rewritten before fill saturates again,
  // so dropping the flushing bit is invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (flush) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= nxt;
      if (!full) fill <= fill + FW'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with Mealy
// match, registered copy and saturating counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter int                 CNT_W   = CNT_W_DEF,
  parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(PAT_RST_DEF),
  parameter bit                 OVL_RST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               x_valid,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               ovl_in,
  input  logic               pat_load,
  input  logic               cnt_clr,
  output logic               z,
  output logic               z_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic [PAT_LEN-1:0] pattern
);

  logic [PAT_LEN-1:0] pat_r;
  ovl_mode_t          ovl_r;
  logic [PAT_LEN-2:0] hist;
  logic               full;
  logic               accept;
  logic               flush;
  logic [CNT_W-1:0]   cnt_inc;

  assign accept  = x_valid && !pat_load;
  assign z       = accept && full
                && ({hist, x} == pat_r);
  assign flush   = pat_load
                || (z && ovl_r == NON_OVL);
  assign pattern = pat_r;
  assign cnt_inc = match_cnt + CNT_W'(1);

  seq_det_hist #(
    .PAT_LEN (PAT_LEN)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .flush    (flush),
    .x        (x),
    .hist     (hist),
    .full     (full)
  );

  // Pattern and overlap mode in force
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r <= PAT_RST;
      ovl_r <= ovl_mode_t'(OVL_RST);
    end else if (pat_load) begin
      pat_r <= pat_in;
      ovl_r <= ovl_mode_t'(ovl_in);
    end
  end

  // Registered copy of the Mealy match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_q <= 1'b0;
    else        z_q <= z;
  end

  // Saturating match counter; clear beats a match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (z && !(&match_cnt)) begin
      match_cnt <= cnt_inc;
      if (&cnt_inc) cnt_sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param over
// three parameter sets (default, CNT_W=2, PAT_LEN=6).
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x;
  logic       ovl_in;
  logic [5:0] pat_in;
  logic [2:0] xv, pl, cc;

  logic       za, zqa, sata;
  logic [7:0] cnta;
  logic [3:0] pata;
  logic       zb, zqb, satb;
  logic [1:0] cntb;
  logic [3:0] patb;
  logic       zc, zqc, satc;
  logic [7:0] cntc;
  logic [5:0] patc;

  always #5 clk = ~clk;

  seq_detector_param u_a (
    .clk(clk), .rst_n(rst_n), .x(x),
    .x_valid(xv[0]), .pat_in(pat_in[3:0]),
    .ovl_in(ovl_in), .pat_load(pl[0]),
    .cnt_clr(cc[0]), .z(za), .z_q(zqa),
    .match_cnt(cnta), .cnt_sat(sata),
    .pattern(pata)
  );

  seq_detector_param #(.CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .x(x),
    .x_valid(xv[1]), .pat_in(pat_in[3:0]),
    .ovl_in(ovl_in), .pat_load(pl[1]),
    .cnt_clr(cc[1]), .z(zb), .z_q(zqb),
    .match_cnt(cntb), .cnt_sat(satb),
    .pattern(patb)
  );

  seq_detector_param #(.PAT_LEN(6)) u_c (
    .clk(clk), .rst_n(rst_n), .x(x),
    .x_valid(xv[2]), .pat_in(pat_in),
    .ovl_in(ovl_in), .pat_load(pl[2]),
    .cnt_clr(cc[2]), .z(zc), .z_q(zqc),
    .match_cnt(cntc), .cnt_sat(satc),
    .pattern(patc)
  );

  typedef struct {
    int    id;
    string nm;
    bit    z;
    bit    zq;
    bit    ckc;
    int    cnt;
    bit    sat;
    bit    ckp;
    int    pat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against queued
  // expectations at the falling edge
  exp_t        e;
  logic [31:0] oz, ozq, ocnt, osat, opat;
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.id)
        0: begin
          oz = 32'(za); ozq = 32'(zqa);
          ocnt = 32'(cnta); osat = 32'(sata);
          opat = 32'(pata);
        end
        1: begin
          oz = 32'(zb); ozq = 32'(zqb);
          ocnt = 32'(cntb); osat = 32'(satb);
          opat = 32'(patb);
        end
        default: begin
          oz = 32'(zc); ozq = 32'(zqc);
          ocnt = 32'(cntc); osat = 32'(satc);
          opat = 32'(patc);
        end
      endcase
      cmp({e.nm, ".z"}, oz, 32'(e.z));
      cmp({e.nm, ".z_q"}, ozq, 32'(e.zq));
      if (e.ckc) begin
        cmp({e.nm, ".cnt"}, ocnt, e.cnt);
        cmp({e.nm, ".sat"}, osat, 32'(e.sat));
      end
      if (e.ckp)
        cmp({e.nm, ".pattern"}, opat, e.pat);
    end
  end

  task automatic push_exp(
    input int id, input bit ez, input bit ezq,
    input bit ckc, input int ec, input bit es,
    input bit ckp, input int ep,
    input string nm);
    exp_t n;
    n.id = id; n.nm = nm; n.z = ez; n.zq = ezq;
    n.ckc = ckc; n.cnt = ec; n.sat = es;
    n.ckp = ckp; n.pat = ep;
    sb.push_back(n);
  endtask

  task automatic cyc(
    input int id, input bit v, input bit b,
    input bit l, input bit c,
    input bit ez, input bit ezq,
    input bit ckc, input int ec, input bit es,
    input bit ckp, input int ep,
    input string nm);
    @(posedge clk);
    #1;
    xv = '0; pl = '0; cc = '0;
    xv[id] = v; pl[id] = l; cc[id] = c;
    x = b;
    push_exp(id, ez, ezq, ckc, ec, es,
             ckp, ep, nm);
  endtask

  task automatic bt(input int id, input bit b,
                    input bit ez, input bit ezq,
                    input string nm);
    cyc(id, 1, b, 0, 0, ez, ezq,
        0, 0, 0, 0, 0, nm);
  endtask

  task automatic idle(input int id,
                      input bit ezq,
                      input int ec, input bit es,
                      input int ep,
                      input string nm);
    cyc(id, 0, 0, 0, 0, 0, ezq,
        1, ec, es, 1, ep, nm);
  endtask

  initial begin
    logic [5:0] vb;
    logic [5:0] vz;
    logic [5:0] vq;
    logic [6:0] vc;
    int         m;
    bit         ez4;

    rst_n = 1'b0; x = 1'b0; ovl_in = 1'b0;
    pat_in = '0; xv = '0; pl = '0; cc = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state of each instance
    idle(0, 0, 0, 0, 'hA, "rst_a");
    idle(1, 0, 0, 0, 'hA, "rst_b");
    idle(2, 0, 0, 0, 'h0A, "rst_c");

    // default 1010, overlapping
    vb = 6'b101010; vz = 6'b000101;
    vq = 6'b000010;
    for (int i = 0; i < 6; i++)
      bt(0, vb[5-i], vz[5-i], vq[5-i], "t1_bit");
    idle(0, 1, 2, 0, 'hA, "t1_end0");
    idle(0, 0, 2, 0, 'hA, "t1_end1");
    cyc(0, 0, 0, 0, 1, 0, 0,
        1, 2, 0, 0, 0, "t1_clr");

    // load 1010 non-overlapping; x dropped
    pat_in = 6'b001010; ovl_in = 1'b0;
    cyc(0, 1, 1, 1, 0, 0, 0,
        1, 0, 0, 0, 0, "t2_load");
    vz = 6'b000100; vq = 6'b000010;
    for (int i = 0; i < 6; i++)
      bt(0, vb[5-i], vz[5-i], vq[5-i], "t2_bit");
    idle(0, 0, 1, 0, 'hA, "t2_end");

    // overlapping with a 3-cycle gap
    ovl_in = 1'b1;
    cyc(0, 0, 0, 1, 0, 0, 0,
        0, 0, 0, 0, 0, "t3_load");
    bt(0, 1, 0, 0, "t3_b1");
    bt(0, 0, 0, 0, "t3_b2");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 0, 0, 0, 0,
          0, 0, 0, 0, 0, "t3_gap");
    bt(0, 1, 0, 0, "t3_b3");
    bt(0, 0, 1, 0, "t3_b4");
    idle(0, 1, 2, 0, 'hA, "t3_zq");
    idle(0, 0, 2, 0, 'hA, "t3_end");

    // clear coincident with a match wins
    bt(0, 1, 0, 0, "cz_b1");
    cyc(0, 1, 0, 0, 1, 1, 0,
        0, 0, 0, 0, 0, "cz_b2");
    idle(0, 1, 0, 0, 'hA, "cz_end");

    // CNT_W=2 saturation, 10 repeated x7
    m = 0;
    for (int i = 1; i <= 14; i++) begin
      ez4 = (i >= 4) && (i % 2 == 0);
      cyc(1, 1, bit'(i % 2), 0, 0, ez4,
          (i >= 5) && (i % 2 == 1),
          1, (m > 3) ? 3 : m, m >= 3,
          0, 0, "t4_bit");
      if (ez4) m++;
    end
    idle(1, 1, 3, 1, 'hA, "t4_sat");
    cyc(1, 0, 0, 0, 1, 0, 0,
        1, 3, 1, 0, 0, "t4_clr");
    idle(1, 0, 0, 0, 'hA, "t4_end");

    // PAT_LEN=6, load mid-stream
    pat_in = 6'b110011; ovl_in = 1'b1;
    bt(2, 1, 0, 0, "t5_pre1");
    bt(2, 1, 0, 0, "t5_pre2");
    cyc(2, 1, 0, 1, 0, 0, 0,
        0, 0, 0, 0, 0, "t5_load");
    vc = 7'b0110011;
    for (int i = 0; i < 7; i++)
      bt(2, vc[6-i], i == 6, 0, "t5_bit");
    idle(2, 1, 1, 0, 'h33, "t5_end");

    // reset mid-stream restores defaults
    pat_in = 6'b000110; ovl_in = 1'b1;
    cyc(0, 0, 0, 1, 0, 0, 0,
        0, 0, 0, 1, 'hA, "t6_load");
    bt(0, 0, 0, 0, "t6_s1");
    bt(0, 1, 0, 0, "t6_s2");
    bt(0, 1, 0, 0, "t6_s3");
    bt(0, 0, 1, 0, "t6_s4");
    cyc(0, 1, 1, 0, 0, 0, 1,
        1, 1, 0, 1, 'h6, "t6_r1");
    cyc(0, 1, 0, 0, 0, 0, 0,
        1, 1, 0, 0, 0, "t6_r2");
    bt(0, 1, 0, 0, "t6_r3");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    xv = '0; pl = '0; cc = '0;
    push_exp(0, 0, 0, 1, 0, 0, 1, 'hA,
             "t6_inrst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 1, 0, 0, 0, 0, 0,
        1, 0, 0, 1, 'hA, "t6_after");
    idle(0, 0, 0, 0, 'hA, "t6_end");

    @(posedge clk);
    @(negedge clk);
    #1;
    cmp("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector and the successor to the fixed 4-bit Mealy detectors in the mini-project. It watches a one-bit serial stream and compares it against a pattern of parametrised length, loaded at run time. Overlapping or non-overlapping detection is selected at run time. It produces a Mealy match pulse, a registered Moore copy, and a saturating match counter for the test harness.

## Interface
Parameters:
- `PAT_LEN`, default 4: pattern length in bits; legal range 2..32.
- `CNT_W`, default 8: match counter width.
- `PAT_RST`, default `4'b1010` zero-extended to `PAT_LEN`: pattern in force after reset.
- `OVL_RST`, default 1: overlap mode in force after reset (1 = overlapping).

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; everything is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `x`, in, 1: serial data bit.
- `x_valid`, in, 1: `x` is consumed this cycle.
- `pat_in`, in, `PAT_LEN`: new pattern. MSB is the first bit in time.
- `ovl_in`, in, 1: new overlap mode.
- `pat_load`, in, 1: latch `pat_in`/`ovl_in` and flush the history.
- `cnt_clr`, in, 1: synchronous clear of `match_cnt`/`cnt_sat`.
- `z`, out, 1: combinational Mealy match for the current `x`.
- `z_q`, out, 1: `z` registered, one cycle later.
- `match_cnt`, out, `CNT_W`: number of matches, saturating.
- `cnt_sat`, out, 1: sticky flag; `match_cnt` has reached all-ones.
- `pattern`, out, `PAT_LEN`: pattern currently in force.

## Operation
State:
- `hist[PAT_LEN-2:0]` holds the most recent accepted bits; bit 0 is the newest.
- `fill` counts bits accepted since the last flush and saturates at `PAT_LEN-1`.
- `pat_r` and `ovl_r` hold the pattern and mode in force.

Match condition:
- `z = x_valid && !pat_load && fill == PAT_LEN-1 && {hist, x} == pat_r`.

On each accepted bit (`x_valid` high, `pat_load` low):
- Shift: `hist <= {hist[PAT_LEN-3:0], x}`, and `fill` increments (saturating).
- If `z` is high and `ovl_r` is 0, flush: `fill <= 0`. The next match then needs `PAT_LEN` fresh bits.
- If `z` is high and `ovl_r` is 1, `fill` stays saturated, so suffix bits can start a new match.

`x_valid` low: hold all state; `z` is 0.

`pat_load` high:
- `pat_r <= pat_in`, `ovl_r <= ovl_in`, `hist <= 0`, `fill <= 0`.
- Any simultaneous `x` is discarded and `z` is 0.
- `match_cnt` is not touched.

Counter:
- When `z` is high, `match_cnt` increments unless it is all-ones.
- `cnt_sat` sets when `match_cnt` becomes all-ones and stays set.
- `cnt_clr` zeroes both.
- `cnt_clr` and `z` in the same cycle: clear wins; that match is not counted.

Reset values:
- `hist`, `fill`, `z_q`, `match_cnt`, `cnt_sat` are 0.
- `pat_r = PAT_RST`, `ovl_r = OVL_RST`, so `pattern = PAT_RST`.
- `z` is combinationally 0 while `fill < PAT_LEN-1`.
- Reset mid-stream discards any partial match; no `z_q` pulse is generated for bits before reset.

## Timing
- `z`: zero-cycle latency from `x`/`x_valid`. It is a Mealy output and depends on `x`.
- `z_q`, `match_cnt`, `cnt_sat`, `pattern`: updated at the edge where the triggering input is sampled, visible the following cycle.
- The first possible match is the `PAT_LEN`-th accepted bit after reset, a load, or a non-overlap match.
- Back-to-back `x_valid` is supported at one bit per clock. Gaps of any length are transparent.

## Structure
Package `seq_det_pkg`:
- `typedef enum logic {NON_OVL=0, OVL=1} ovl_mode_t`.
- Default constants `PAT_RST_DEF = 4'b1010` and `CNT_W_DEF = 8`.

Sub-module `seq_det_hist`:
- Holds the history shift register and the `fill` counter.
- Inputs: `shift_en`, `flush`, `x`.
- Outputs: `hist`, `full` (= `fill == PAT_LEN-1`).

Top-level logic:
- Top level keeps the compare, the mode handling and the counter.

## Test plan
1. Defaults (`1010`, overlap); send 1,0,1,0,1,0 with `x_valid` high each cycle → `z` high on bits 4 and 6; `match_cnt=2` two cycles after bit 6.
2. `pat_load` with `pat_in=4'b1010`, `ovl_in=0`; same stream → `z` high on bit 4 only; `match_cnt=1`.
3. Overlap stream 1,0,1,0 with `x_valid` low for 3 cycles between bits 2 and 3 → `z` on bit 4 only; no `z` during the gaps; `z_q` one cycle after `z`.
4. `CNT_W=2`, overlap, stream `10` repeated ×7 (matches on bits 4,6,8,10,12,14) → `match_cnt` sticks at 3; `cnt_sat` is 1 from the third match; `cnt_clr` → both 0.
5. `PAT_LEN=6`, load `6'b110011` during stream 1,1,0,0 with `pat_load` and `x` coincident on the third bit → bits before and at the load are dropped; `z` only after 6 fresh matching bits.
6. Assert `rst_n` low after 1,0,1, then release and send 0 → no `z`; `pattern=PAT_RST`; `match_cnt=0`.
